// File: rtl/wave_sequencer_pkg.sv
// ============================================================================
// Module : wave_sequencer_pkg
// Brief  : State codes, default geometry and helpers for the wave sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wave_sequencer_pkg;

    localparam int DEFAULT_WAVE_SIZE  = 32;
    localparam int DEFAULT_LANE_WIDTH = 16;

    // Encodings are shared with the register file and ALU; do not renumber.
    typedef enum logic [2:0] {
        SIMD_IDLE    = 3'd0,
        SIMD_FETCH   = 3'd1,
        SIMD_DECODE  = 3'd2,
        SIMD_REQUEST = 3'd3,
        SIMD_WAIT    = 3'd4,
        SIMD_EXECUTE = 3'd5,
        SIMD_UPDATE  = 3'd6,
        SIMD_DONE    = 3'd7
    } simd_state_t;

    function automatic int cycle_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wave_sequencer_lane_mask_gen.sv
// ============================================================================
// Module : lane_mask_gen
// Brief  : Marks each lane whose global thread index lies inside the block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_mask_gen #(
    parameter int WAVE_SIZE  = 32,
    parameter int LANE_WIDTH = 16,
    parameter int CYCLE_W    = 1
) (
    input  logic [31:0]           wave_id,
    input  logic [CYCLE_W-1:0]    curr_wave_cycle,
    input  logic [31:0]           block_dim,
    output logic [LANE_WIDTH-1:0] lane_mask
);

    // 64-bit base keeps wave_id*WAVE_SIZE from overflowing near the top of the range.
    logic [63:0] base;

    assign base = 64'(wave_id) * 64'(WAVE_SIZE) + 64'(curr_wave_cycle) * 64'(LANE_WIDTH);

    generate
        for (genvar i = 0; i < LANE_WIDTH; i++) begin : g_lane
            assign lane_mask[i] = (base + 64'(i)) < {32'd0, block_dim};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wave_sequencer.sv
// ============================================================================
// Module : wave_sequencer
// Brief  : Per-block SIMD control sequencer (fetch/decode/execute per wave).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_sequencer
    import wave_sequencer_pkg::*;
#(
    parameter int  WAVE_SIZE       = DEFAULT_WAVE_SIZE,
    parameter int  LANE_WIDTH      = DEFAULT_LANE_WIDTH,
    parameter int  PC_WIDTH        = 8,
    localparam int NUM_WAVE_CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
    localparam int CYCLE_W         = cycle_width(NUM_WAVE_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           block_dim,
    input  logic                  fetch_valid,
    input  logic                  decoded_mem_access,
    input  logic                  decoded_branch,
    input  logic                  decoded_ret,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  mem_ready,
    output logic [2:0]            simd_state,
    output logic [CYCLE_W-1:0]    curr_wave_cycle,
    output logic [31:0]           wave_id,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  fetch_req,
    output logic                  lane_enable,
    output logic [LANE_WIDTH-1:0] lane_mask,
    output logic                  busy,
    output logic                  done
);

    simd_state_t         state, state_nxt;
    logic [CYCLE_W-1:0]  cycle_q, cycle_nxt;
    logic [31:0]         wave_q, wave_nxt;
    logic [31:0]         num_waves_q, num_waves_nxt;
    logic [31:0]         dim_q, dim_nxt;
    logic [PC_WIDTH-1:0] pc_q, pc_nxt;
    logic [PC_WIDTH-1:0] target_q, target_nxt;
    logic                mem_q, mem_nxt;
    logic                branch_q, branch_nxt;
    logic                ret_q, ret_nxt;
    logic [31:0]         num_waves_calc;
    logic                last_cycle;
    logic                last_wave;
    logic [LANE_WIDTH-1:0] raw_mask;

    // 33-bit sum so block_dim = 0xFFFFFFFF rounds up without wrapping.
    assign num_waves_calc = 32'(({1'b0, block_dim} + 33'(WAVE_SIZE - 1)) / 33'(WAVE_SIZE));
    assign last_cycle     = (cycle_q == CYCLE_W'(NUM_WAVE_CYCLES - 1));
    assign last_wave      = (wave_q == num_waves_q - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SIMD_IDLE;
            cycle_q     <= '0;
            wave_q      <= '0;
            num_waves_q <= '0;
            dim_q       <= '0;
            pc_q        <= '0;
            target_q    <= '0;
            mem_q       <= 1'b0;
            branch_q    <= 1'b0;
            ret_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cycle_q     <= cycle_nxt;
            wave_q      <= wave_nxt;
            num_waves_q <= num_waves_nxt;
            dim_q       <= dim_nxt;
            pc_q        <= pc_nxt;
            target_q    <= target_nxt;
            mem_q       <= mem_nxt;
            branch_q    <= branch_nxt;
            ret_q       <= ret_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cycle_nxt     = cycle_q;
        wave_nxt      = wave_q;
        num_waves_nxt = num_waves_q;
        dim_nxt       = dim_q;
        pc_nxt        = pc_q;
        target_nxt    = target_q;
        mem_nxt       = mem_q;
        branch_nxt    = branch_q;
        ret_nxt       = ret_q;
        case (state)
            SIMD_IDLE: begin
                if (start) begin
                    dim_nxt       = block_dim;
                    num_waves_nxt = num_waves_calc;
                    wave_nxt      = '0;
                    pc_nxt        = '0;
                    cycle_nxt     = '0;
                    state_nxt     = (block_dim == 32'd0) ? SIMD_DONE : SIMD_FETCH;
                end
            end
            SIMD_FETCH: begin
                if (fetch_valid) state_nxt = SIMD_DECODE;
            end
            SIMD_DECODE: begin
                mem_nxt    = decoded_mem_access;
                branch_nxt = decoded_branch;
                ret_nxt    = decoded_ret;
                target_nxt = branch_target;
                state_nxt  = SIMD_REQUEST;
            end
            SIMD_REQUEST: state_nxt = SIMD_WAIT;
            SIMD_WAIT: begin
                if (!mem_q || mem_ready) state_nxt = SIMD_EXECUTE;
            end
            SIMD_EXECUTE: state_nxt = SIMD_UPDATE;
            SIMD_UPDATE: begin
                if (!last_cycle) begin
                    cycle_nxt = cycle_q + CYCLE_W'(1);
                    state_nxt = SIMD_REQUEST;
                end else begin
                    cycle_nxt = '0;
                    state_nxt = SIMD_FETCH;
                    // ret takes priority over branch; the final ret ends the block.
                    if (ret_q && last_wave) begin
                        state_nxt = SIMD_DONE;
                    end else if (ret_q) begin
                        wave_nxt = wave_q + 32'd1;
                        pc_nxt   = '0;
                    end else if (branch_q) begin
                        pc_nxt = target_q;
                    end else begin
                        pc_nxt = pc_q + PC_WIDTH'(1);
                    end
                end
            end
            SIMD_DONE: state_nxt = SIMD_IDLE;
            default:   state_nxt = SIMD_IDLE;
        endcase
    end

    lane_mask_gen #(
        .WAVE_SIZE  (WAVE_SIZE),
        .LANE_WIDTH (LANE_WIDTH),
        .CYCLE_W    (CYCLE_W)
    ) u_lane_mask_gen (
        .wave_id         (wave_q),
        .curr_wave_cycle (cycle_q),
        .block_dim       (dim_q),
        .lane_mask       (raw_mask)
    );

    assign simd_state      = state;
    assign curr_wave_cycle = cycle_q;
    assign wave_id         = wave_q;
    assign pc              = pc_q;
    assign fetch_req       = (state == SIMD_FETCH);
    assign lane_enable     = state inside {SIMD_REQUEST, SIMD_WAIT, SIMD_EXECUTE, SIMD_UPDATE};
    assign busy            = (state != SIMD_IDLE);
    assign done            = (state == SIMD_DONE);
    assign lane_mask       = (state == SIMD_IDLE || state == SIMD_DONE) ? '0 : raw_mask;

endmodule

`default_nettype wire
